// File: rtl/bitfusion_column_param.sv
// Bit-fusion systolic column: ROWS fused-PE rows sum lane products into a travelling partial
// sum, followed by a saturating group accumulator with a ready/valid output register.
module bitfusion_column_param #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wgt_load_i,
  input  logic [ROWS*32-1:0]     wgt_data_i,
  input  logic [1:0]             cfg_bitwidth_i,
  input  logic                   cfg_sign_x_i,
  input  logic                   cfg_sign_y_i,
  input  logic [7:0]             cfg_acc_len_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [ROWS*32-1:0]     act_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ACC_W-1:0]       out_data_o,
  output logic                   out_ovf_o,
  output logic                   busy_o,
  output logic                   wgt_err_o
);

  localparam int unsigned PSUM_W = 20 + $clog2(ROWS);

  logic [ROWS*32-1:0] wgt_q;
  logic [1:0]         bw_q;
  logic               sx_q, sy_q;
  logic [7:0]         acc_len_q;
  logic               err_q;

  logic stall, en, accept;

  logic                     vin_q;
  logic [ROWS-1:0]          sv_q;
  logic signed [PSUM_W-1:0] ps_q [ROWS];
  logic signed [PSUM_W-1:0] prod [ROWS];
  logic [31:0]              skew_act [ROWS];

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    gov_q, gov_d;
  logic                    out_valid_q, out_valid_d;
  logic [ACC_W-1:0]        out_data_q, out_data_d;
  logic                    out_ovf_q, out_ovf_d;

  function automatic int lane8(input logic [7:0] v, input logic s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  function automatic int lane4(input logic [3:0] v, input logic s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  function automatic int lane2(input logic [1:0] v, input logic s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  // Reserved bitwidth code 2'b11 falls into the 8-bit default.
  function automatic logic signed [PSUM_W-1:0] row_dot(input logic [31:0] a,
                                                       input logic [31:0] w,
                                                       input logic [1:0]  bw,
                                                       input logic        sa,
                                                       input logic        sw);
    int acc;
    acc = 0;
    case (bw)
      2'b01:   for (int l = 0; l < 8; l++)  acc += lane4(a[4*l +: 4], sa) * lane4(w[4*l +: 4], sw);
      2'b10:   for (int l = 0; l < 16; l++) acc += lane2(a[2*l +: 2], sa) * lane2(w[2*l +: 2], sw);
      default: for (int l = 0; l < 4; l++)  acc += lane8(a[8*l +: 8], sa) * lane8(w[8*l +: 8], sw);
    endcase
    return PSUM_W'(acc);
  endfunction

  assign stall      = out_valid_q && !out_ready_i;
  assign en         = !stall;
  assign in_ready_o = !stall && !wgt_load_i;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = vin_q || (|sv_q) || (cnt_q != 8'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wgt_q     <= '0;
      bw_q      <= 2'b00;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      acc_len_q <= 8'd1;
      err_q     <= 1'b0;
    end else if (wgt_load_i) begin
      if (!busy_o) begin
        wgt_q     <= wgt_data_i;
        bw_q      <= cfg_bitwidth_i;
        sx_q      <= cfg_sign_x_i;
        sy_q      <= cfg_sign_y_i;
        acc_len_q <= cfg_acc_len_i;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  // Row r sees its activation slice r cycles late so it meets the travelling partial sum.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [31:0] ch_q [r+1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k <= r; k++) ch_q[k] <= '0;
      end else if (en) begin
        ch_q[0] <= act_data_i[32*r +: 32];
        for (int k = 1; k <= r; k++) ch_q[k] <= ch_q[k-1];
      end
    end
    assign skew_act[r] = ch_q[r];
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      prod[r] = row_dot(skew_act[r], wgt_q[32*r +: 32], bw_q, sx_q, sy_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vin_q <= 1'b0;
      sv_q  <= '0;
      for (int r = 0; r < ROWS; r++) ps_q[r] <= '0;
    end else if (en) begin
      vin_q   <= accept;
      sv_q    <= {sv_q[ROWS-2:0], vin_q};
      ps_q[0] <= prod[0];
      for (int r = 1; r < ROWS; r++) ps_q[r] <= ps_q[r-1] + prod[r];
    end
  end

  logic signed [ACC_W-1:0] col_ext, sat;
  logic [ACC_W:0]          sum_w;
  logic                    add_ovf, last;
  logic [7:0]              eff_len, cnt_inc;

  always_comb begin
    col_ext = ACC_W'(ps_q[ROWS-1]);
    sum_w   = {acc_q[ACC_W-1], acc_q} + {col_ext[ACC_W-1], col_ext};
    add_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    if (!add_ovf) begin
      sat = sum_w[ACC_W-1:0];
    end else if (sum_w[ACC_W]) begin
      sat = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(ACC_W-1){1'b1}}};
    end
    eff_len = (acc_len_q == 8'd0) ? 8'd1 : acc_len_q;
    cnt_inc = cnt_q + 8'd1;
    last    = (cnt_inc == eff_len);

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    gov_d       = gov_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    // A transfer and a completing group on the same edge: the new result wins the register.
    if (en && sv_q[ROWS-1]) begin
      if (last) begin
        out_valid_d = 1'b1;
        out_data_d  = sat;
        out_ovf_d   = gov_q | add_ovf;
        acc_d       = '0;
        cnt_d       = 8'd0;
        gov_d       = 1'b0;
      end else begin
        acc_d = sat;
        cnt_d = cnt_inc;
        gov_d = gov_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      cnt_q       <= 8'd0;
      gov_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      gov_q       <= gov_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign wgt_err_o   = err_q;

endmodule

// File: tb/tb_bitfusion_column_param.sv
// Directed bench for bitfusion_column_param: a 32-bit and a 24-bit accumulator instance share
// stimulus; expected values are hand-computed.
module tb_bitfusion_column_param;

  localparam int unsigned ROWS = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wgt_load;
  logic [ROWS*32-1:0] wgt_data;
  logic [1:0]         cfg_bw;
  logic               sx, sy;
  logic [7:0]         acc_len;
  logic               in_valid;
  logic [ROWS*32-1:0] act_data;
  logic               out_ready;

  logic        in_ready, out_valid, out_ovf, busy, wgt_err;
  logic [31:0] out_data;
  logic        in_ready24, out_valid24, out_ovf24, busy24, wgt_err24;
  logic [23:0] out_data24;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] r_data;
  logic [23:0] r_data24;
  logic        r_ovf, r_ovf24;
  int          r_lat;

  bitfusion_column_param #(.ROWS(ROWS), .ACC_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wgt_load_i(wgt_load), .wgt_data_i(wgt_data),
    .cfg_bitwidth_i(cfg_bw), .cfg_sign_x_i(sx), .cfg_sign_y_i(sy), .cfg_acc_len_i(acc_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .act_data_i(act_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ovf_o(out_ovf), .busy_o(busy), .wgt_err_o(wgt_err)
  );

  bitfusion_column_param #(.ROWS(ROWS), .ACC_W(24)) dut24 (
    .clk_i(clk), .rst_ni(rst_n), .wgt_load_i(wgt_load), .wgt_data_i(wgt_data),
    .cfg_bitwidth_i(cfg_bw), .cfg_sign_x_i(sx), .cfg_sign_y_i(sy), .cfg_acc_len_i(acc_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready24), .act_data_i(act_data),
    .out_valid_o(out_valid24), .out_ready_i(out_ready), .out_data_o(out_data24),
    .out_ovf_o(out_ovf24), .busy_o(busy24), .wgt_err_o(wgt_err24)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic load_cfg(input logic [1:0] bw, input logic s_x, input logic s_y,
                          input logic [7:0] len, input logic [7:0] wbyte);
    @(negedge clk);
    wgt_load = 1'b1;
    wgt_data = {(ROWS*4){wbyte}};
    cfg_bw   = bw;
    sx       = s_x;
    sy       = s_y;
    acc_len  = len;
    @(negedge clk);
    wgt_load = 1'b0;
  endtask

  // Presents one vector across the next rising edge; returns that edge's cycle number.
  task automatic send_vec(input logic [7:0] abyte, output int acc_cyc);
    in_valid = 1'b1;
    act_data = {(ROWS*4){abyte}};
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int start, input int max_cyc);
    r_lat = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        r_lat    = cyc - start;
        r_data   = out_data;
        r_ovf    = out_ovf;
        r_data24 = out_data24;
        r_ovf24  = out_ovf24;
        break;
      end
    end
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic count_valid(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int a1, a2, a3, pulses;
    rst_n = 1'b0; wgt_load = 1'b0; wgt_data = '0; cfg_bw = 2'b00; sx = 1'b0; sy = 1'b0;
    acc_len = 8'd0; in_valid = 1'b0; act_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_wgt_err", {31'd0, wgt_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 8-bit unsigned, w=2, a=1: 16 rows * 4 lanes * 2 = 128
    load_cfg(2'b00, 1'b0, 1'b0, 8'd1, 8'h02);
    send_vec(8'h01, a1);
    wait_out("basic", a1, 40);
    check_eq("basic_latency", r_lat, 32'd17);
    check_eq("basic_data", r_data, 32'd128);
    check_eq("basic_ovf", {31'd0, r_ovf}, 32'd0);
    count_valid(5, pulses);
    check_eq("basic_single_pulse", pulses, 32'd0);

    // 2-bit signed, a lanes -1, w lanes +1: row -16, column -256
    load_cfg(2'b10, 1'b1, 1'b1, 8'd1, 8'h55);
    send_vec(8'hFF, a1);
    wait_out("signed2", a1, 40);
    check_eq("signed2_data", r_data, 32'hFFFF_FF00);
    check_eq("signed2_data24", {8'd0, r_data24}, 32'h00FF_FF00);
    check_eq("signed2_ovf", {31'd0, r_ovf}, 32'd0);

    // Group of 3 back-to-back: 3*128 = 384, then a fresh group of a=2: 3*256 = 768
    load_cfg(2'b00, 1'b0, 1'b0, 8'd3, 8'h02);
    send_vec(8'h01, a1);
    send_vec(8'h01, a2);
    send_vec(8'h01, a3);
    wait_out("grp1", a3, 40);
    check_eq("grp1_latency", r_lat, 32'd17);
    check_eq("grp1_data", r_data, 32'd384);
    count_valid(5, pulses);
    check_eq("grp1_single_pulse", pulses, 32'd0);
    send_vec(8'h02, a1);
    send_vec(8'h02, a2);
    send_vec(8'h02, a3);
    wait_out("grp2", a3, 40);
    check_eq("grp2_data", r_data, 32'd768);

    // All 0xFF: column 4161600, x3 = 12484800; 24-bit accumulator clamps to 8388607
    load_cfg(2'b00, 1'b0, 1'b0, 8'd3, 8'hFF);
    send_vec(8'hFF, a1);
    send_vec(8'hFF, a2);
    send_vec(8'hFF, a3);
    wait_out("sat", a3, 40);
    check_eq("sat_data32", r_data, 32'd12484800);
    check_eq("sat_ovf32", {31'd0, r_ovf}, 32'd0);
    check_eq("sat_data24", {8'd0, r_data24}, 32'd8388607);
    check_eq("sat_ovf24", {31'd0, r_ovf24}, 32'd1);

    // Backpressure: A=128 held while out_ready=0, B=256 lands on the transfer edge
    load_cfg(2'b00, 1'b0, 1'b0, 8'd1, 8'h02);
    out_ready = 1'b0;
    send_vec(8'h01, a1);
    send_vec(8'h02, a2);
    wait_out("stall", a1, 40);
    check_eq("stall_data", r_data, 32'd128);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall_hold_data", out_data, 32'd128);
      check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("stall_next_valid", {31'd0, out_valid}, 32'd1);
    check_eq("stall_next_data", out_data, 32'd256);
    @(negedge clk);
    check_eq("stall_no_dup", {31'd0, out_valid}, 32'd0);

    // Reload while busy is ignored and flagged; group still uses w=2
    load_cfg(2'b00, 1'b0, 1'b0, 8'd3, 8'h02);
    send_vec(8'h01, a1);
    load_cfg(2'b00, 1'b0, 1'b0, 8'd1, 8'h05);
    check_eq("busy_load_err", {31'd0, wgt_err}, 32'd1);
    send_vec(8'h01, a2);
    send_vec(8'h01, a3);
    wait_out("busy_load", a3, 40);
    check_eq("busy_load_data", r_data, 32'd384);
    check_eq("busy_load_err_sticky", {31'd0, wgt_err}, 32'd1);

    // Reset mid-group clears everything; next group is clean
    load_cfg(2'b00, 1'b0, 1'b0, 8'd3, 8'h02);
    send_vec(8'h01, a1);
    repeat (20) @(negedge clk);
    check_eq("midgrp_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_out_data", out_data, 32'd0);
    check_eq("midrst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_wgt_err", {31'd0, wgt_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    load_cfg(2'b00, 1'b0, 1'b0, 8'd3, 8'h02);
    send_vec(8'h01, a1);
    send_vec(8'h01, a2);
    send_vec(8'h01, a3);
    wait_out("post_rst", a3, 40);
    check_eq("post_rst_latency", r_lat, 32'd17);
    check_eq("post_rst_data", r_data, 32'd384);
    check_eq("post_rst_ovf", {31'd0, r_ovf}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
